// File: rtl/reg_file_scoreboard.sv
// Purpose : 8 x WIDTH register file with per-register pending bits for long-latency (MULT/DIV) ops.
// Latency : reads are combinational; writes, issues and retires take effect at the next rising edge.
// Backpr. : Stall is raised on RAW/WAW against a pending register; LD_REG/Issue_LL are ignored while stalled.
//
// Ports: Clk/Reset (sync, active-high); DR/SR1/SR2 + *_USE from the address mux; LD_REG/Data_in bus write;
//        Issue_LL marks DR pending; Retire/Retire_DR/Retire_data late write-back; SR1_OUT/SR2_OUT operands;
//        Busy registered pending vector; Stall combinational hazard flag.
module reg_file_scoreboard #(
    parameter int WIDTH = 16,
    parameter bit FWD   = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [2:0]       DR,
    input  logic [2:0]       SR1,
    input  logic [2:0]       SR2,
    input  logic             DR_USE,
    input  logic             SR1_USE,
    input  logic             SR2_USE,
    input  logic             LD_REG,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             Issue_LL,
    input  logic             Retire,
    input  logic [2:0]       Retire_DR,
    input  logic [WIDTH-1:0] Retire_data,
    output logic [WIDTH-1:0] SR1_OUT,
    output logic [WIDTH-1:0] SR2_OUT,
    output logic [7:0]       Busy,
    output logic             Stall
);

    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];
    logic [7:0]       busy_q;
    logic [7:0]       busy_d;

    logic       ret_ok;
    logic [7:0] hz;
    logic       ld_g;
    logic       iss_g;

    // A retire is only meaningful for a register still marked pending; anything else
    // (e.g. a write-back arriving after a reset flushed the scoreboard) is dropped.
    assign ret_ok = Retire & busy_q[Retire_DR];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            // A register retiring this cycle is no longer a hazard when bypass is enabled,
            // since its value is forwarded to the readers in the same cycle.
            hz[i] = busy_q[i] & ~(FWD & ret_ok & (Retire_DR == 3'(i)));
        end
    end

    assign Stall = (SR1_USE & hz[SR1]) | (SR2_USE & hz[SR2]) | (DR_USE & hz[DR]);
    assign ld_g  = LD_REG & ~Stall;
    assign iss_g = Issue_LL & ~Stall;

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = regs_q[i];
            // Bus write beats a retire to the same register.
            if (ld_g && (DR == 3'(i))) begin
                regs_d[i] = Data_in;
            end else if (ret_ok && (Retire_DR == 3'(i))) begin
                regs_d[i] = Retire_data;
            end
        end
        if (ret_ok) begin
            busy_d[Retire_DR] = 1'b0;
        end
        // Applied after the retire clear so a fresh issue to the retiring register stays pending.
        if (iss_g) begin
            busy_d[DR] = 1'b1;
        end
    end

    always_comb begin
        SR1_OUT = regs_q[SR1];
        SR2_OUT = regs_q[SR2];
        if (FWD) begin
            if (ld_g && (DR == SR1)) begin
                SR1_OUT = Data_in;
            end else if (ret_ok && (Retire_DR == SR1)) begin
                SR1_OUT = Retire_data;
            end
            if (ld_g && (DR == SR2)) begin
                SR2_OUT = Data_in;
            end else if (ret_ok && (Retire_DR == SR2)) begin
                SR2_OUT = Retire_data;
            end
        end
    end

    assign Busy = busy_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy_q <= '0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Purpose : directed-vector bench for reg_file_scoreboard with a queued scoreboard and separate monitor.
// Latency : expectations are checked mid-cycle against the combinational outputs of the same cycle.
// Backpr. : none; the bench drives one vector per clock.
module tb_reg_file_scoreboard;

    localparam int WIDTH = 16;

    typedef struct {
        string            nm;
        logic [WIDTH-1:0] sr1;
        logic [WIDTH-1:0] sr2;
        logic [7:0]       busy;
        logic             stall;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       dr = '0, sr1 = '0, sr2 = '0, rdr = '0;
    logic             dr_use = 1'b0, s1_use = 1'b0, s2_use = 1'b0;
    logic             ld = 1'b0, iss = 1'b0, ret = 1'b0;
    logic [WIDTH-1:0] din = '0, rdat = '0;
    logic [WIDTH-1:0] sr1_out, sr2_out;
    logic [7:0]       busy;
    logic             stall;

    logic chk_vld = 1'b0;
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    reg_file_scoreboard #(.WIDTH(WIDTH), .FWD(1'b1)) dut (
        .Clk(clk), .Reset(rst), .DR(dr), .SR1(sr1), .SR2(sr2),
        .DR_USE(dr_use), .SR1_USE(s1_use), .SR2_USE(s2_use),
        .LD_REG(ld), .Data_in(din), .Issue_LL(iss),
        .Retire(ret), .Retire_DR(rdr), .Retire_data(rdat),
        .SR1_OUT(sr1_out), .SR2_OUT(sr2_out), .Busy(busy), .Stall(stall)
    );

    // Monitor: whenever a checked vector is on the inputs, pop its expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_vld) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL underflow: output presented with no expectation queued");
                end else begin
                    e = sb_q.pop_front();
                    if (sr1_out !== e.sr1 || sr2_out !== e.sr2 || busy !== e.busy || stall !== e.stall) begin
                        n_fail++;
                        $display("FAIL %s: got sr1=%h sr2=%h busy=%h stall=%b, want sr1=%h sr2=%h busy=%h stall=%b",
                                 e.nm, sr1_out, sr2_out, busy, stall, e.sr1, e.sr2, e.busy, e.stall);
                    end
                end
            end
        end
    end

    task automatic vec(input string nm, input logic r,
                       input logic [2:0] d, input logic [2:0] a, input logic [2:0] b,
                       input logic du, input logic au, input logic bu,
                       input logic l, input logic [WIDTH-1:0] di, input logic is,
                       input logic rt, input logic [2:0] rd, input logic [WIDTH-1:0] rv,
                       input logic chk,
                       input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2,
                       input logic [7:0] eb, input logic es);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; dr = d; sr1 = a; sr2 = b;
        dr_use = du; s1_use = au; s2_use = bu;
        ld = l; din = di; iss = is; ret = rt; rdr = rd; rdat = rv;
        if (chk) begin
            e.nm = nm; e.sr1 = e1; e.sr2 = e2; e.busy = eb; e.stall = es;
            sb_q.push_back(e);
        end
        chk_vld = chk;
    endtask

    initial begin
        //   name          rst dr sr1 sr2 du au bu ld din      is rt rdr rdat     chk e_sr1    e_sr2    busy   stall
        vec("rst_cycle",   1, 0, 0, 0, 0, 0, 0, 0, 16'h0,   0, 0, 0, 16'h0,   0, 16'h0,   16'h0,   8'h00, 0);
        vec("reset_state", 0, 0, 3, 5, 0, 1, 1, 0, 16'h0,   0, 0, 0, 16'h0,   1, 16'h0,   16'h0,   8'h00, 0);
        vec("ld_fwd",      0, 2, 2, 5, 1, 1, 0, 1, 16'hBEEF,0, 0, 0, 16'h0,   1, 16'hBEEF,16'h0,   8'h00, 0);
        vec("r2_stored",   0, 0, 2, 2, 0, 1, 1, 0, 16'h0,   0, 0, 0, 16'h0,   1, 16'hBEEF,16'hBEEF,8'h00, 0);
        vec("issue_r4",    0, 4, 0, 0, 1, 0, 0, 0, 16'h0,   1, 0, 0, 16'h0,   1, 16'h0,   16'h0,   8'h00, 0);
        vec("raw_stall",   0, 0, 2, 4, 0, 1, 1, 0, 16'h0,   0, 0, 0, 16'h0,   1, 16'hBEEF,16'h0,   8'h10, 1);
        vec("retire_fwd",  0, 0, 2, 4, 0, 1, 1, 0, 16'h0,   0, 1, 4, 16'h0042,1, 16'hBEEF,16'h0042,8'h10, 0);
        vec("r4_retired",  0, 0, 2, 4, 0, 1, 1, 0, 16'h0,   0, 0, 0, 16'h0,   1, 16'hBEEF,16'h0042,8'h00, 0);
        vec("issue_r6",    0, 6, 6, 0, 1, 0, 0, 0, 16'h0,   1, 0, 0, 16'h0,   1, 16'h0,   16'h0,   8'h00, 0);
        vec("waw_stall",   0, 6, 6, 0, 1, 0, 0, 1, 16'hAAAA,0, 0, 0, 16'h0,   1, 16'h0,   16'h0,   8'h40, 1);
        vec("retire_r6",   0, 0, 6, 0, 0, 0, 0, 0, 16'h0,   0, 1, 6, 16'h0007,1, 16'h0007,16'h0,   8'h40, 0);
        vec("r6_is_7",     0, 0, 6, 0, 0, 0, 0, 0, 16'h0,   0, 0, 0, 16'h0,   1, 16'h0007,16'h0,   8'h00, 0);
        vec("ld_retry",    0, 6, 6, 0, 1, 0, 0, 1, 16'hAAAA,0, 0, 0, 16'h0,   1, 16'hAAAA,16'h0,   8'h00, 0);
        vec("r6_written",  0, 0, 6, 6, 0, 1, 1, 0, 16'h0,   0, 0, 0, 16'h0,   1, 16'hAAAA,16'hAAAA,8'h00, 0);
        vec("issue_r1",    0, 1, 0, 0, 1, 0, 0, 0, 16'h0,   1, 0, 0, 16'h0,   1, 16'h0,   16'h0,   8'h00, 0);
        vec("ld_beats_ret",0, 1, 1, 6, 1, 1, 0, 1, 16'h0005,0, 1, 1, 16'h0009,1, 16'h0005,16'hAAAA,8'h02, 0);
        vec("r1_is_5",     0, 0, 1, 6, 0, 1, 0, 0, 16'h0,   0, 0, 0, 16'h0,   1, 16'h0005,16'hAAAA,8'h00, 0);
        vec("issue_r3",    0, 3, 0, 0, 1, 0, 0, 0, 16'h0,   1, 0, 0, 16'h0,   1, 16'h0,   16'h0,   8'h00, 0);
        vec("busy3_at_rst",1, 0, 0, 0, 0, 0, 0, 0, 16'h0,   0, 0, 0, 16'h0,   1, 16'h0,   16'h0,   8'h08, 0);
        vec("ret_dropped", 0, 0, 3, 2, 0, 1, 1, 0, 16'h0,   0, 1, 3, 16'h1234,1, 16'h0,   16'h0,   8'h00, 0);
        vec("r3_still_0",  0, 0, 3, 6, 0, 1, 1, 0, 16'h0,   0, 0, 0, 16'h0,   1, 16'h0,   16'h0,   8'h00, 0);
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
        ret = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never matched by DUT output, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
